// File: rtl/img_pkg.sv
// Shared definitions for the processed-image UART streamer.
//   IMG_W_DEF / IMG_H_DEF / ADDR_W_DEF : default image geometry and RAM address width
//   NUM_PIXELS                         : pixels per image at the default geometry
//   ctrl_state_t                       : transfer controller states
//   ser_state_t                        : byte serializer states
package img_pkg;

  localparam int IMG_W_DEF  = 100;
  localparam int IMG_H_DEF  = 100;
  localparam int ADDR_W_DEF = 14;
  localparam int NUM_PIXELS = IMG_W_DEF * IMG_H_DEF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    STREAM,
    TRAIL,
    DONE
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer: start bit (0), eight data bits LSB first, stop bit (1),
// each bit held CLKS_PER_BIT clocks. A byte is accepted only while ready is high.
//   clk, rst : clock, asynchronous active-high reset
//   load     : accept din this cycle (honoured only when ready)
//   din      : byte to send
//   ready    : serializer idle, able to accept a byte
//   tx       : serial line, idles high
module uart_tx_byte
  import img_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  // The stop bit is counted one clock short: the S_IDLE cycle that follows
  // supplies its final clock, so a byte loaded then starts with no idle gap.
  localparam logic [CNT_W-1:0] CNT_STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);

  ser_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, sh_nxt;
  logic             tx_nxt;

  assign ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      tx      <= tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= sh_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    tx_nxt    = tx;
    case (state)
      S_IDLE: begin
        if (load) begin
          sh_nxt    = din;
          tx_nxt    = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
          state_nxt = S_DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = S_STOP;
          end else begin
            bit_nxt = bit_idx + 3'd1;
            sh_nxt  = {1'b0, shreg[7:1]};
            tx_nxt  = shreg[1];
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == CNT_STOP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/image_uart_streamer.sv
// Streams the IMG_W x IMG_H processed-image RAM out as back-to-back UART 8N1 bytes,
// raster order, one transfer per rising edge of start.
// Optional build macro IMG_TX_CHECKSUM_EN: appends one byte holding the 8-bit
// modulo-256 sum of all transmitted pixels.
//   clk, rst : clock, asynchronous active-high reset
//   start    : level from the filter; a 0->1 transition starts one image
//   rd_addr  : processed-RAM read address (synchronous read, 1-cycle latency)
//   rd_data  : processed-RAM read data
//   tx       : UART line, idles high
//   busy     : transfer in progress (start edge through tx_done)
//   tx_done  : one-cycle pulse after the last stop bit
module image_uart_streamer
  import img_pkg::*;
#(
  parameter int IMG_W        = IMG_W_DEF,
  parameter int IMG_H        = IMG_H_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  ctrl_state_t       state, state_nxt;
  logic              start_q;
  logic              start_armed;
  logic              start_go;
  logic              pix_load;
  logic              capture;
  logic              pf_valid;
  logic              cap_pend;
  logic              last_loaded;
  logic [ADDR_W-1:0] pix_cnt;
  logic [7:0]        pf_data_p1;
  logic              ser_load;
  logic [7:0]        ser_din;
  logic              ser_ready;
`ifdef IMG_TX_CHECKSUM_EN
  logic              sum_load;
  logic [7:0]        sum_p1;
`endif

  // Prefetch register is written by the first read (CAPTURE) and by the read
  // issued alongside every byte load (cap_pend).
  assign capture = (state == CAPTURE) || cap_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    pix_load  = 1'b0;
    ser_load  = 1'b0;
    ser_din   = pf_data_p1;
    busy      = (state != IDLE);
    tx_done   = 1'b0;
`ifdef IMG_TX_CHECKSUM_EN
    sum_load  = 1'b0;
`endif
    case (state)
      IDLE: begin
        // start_armed blocks a start that was already high out of reset.
        if (start && !start_q && start_armed) begin
          start_go  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = STREAM;
      STREAM: begin
        if (ser_ready && pf_valid) begin
          pix_load = 1'b1;
          ser_load = 1'b1;
        end else if (ser_ready && last_loaded) begin
`ifdef IMG_TX_CHECKSUM_EN
          // Checksum goes out in the final stop-bit clock so it follows with no gap.
          sum_load  = 1'b1;
          ser_load  = 1'b1;
          ser_din   = sum_p1;
          state_nxt = TRAIL;
`else
          state_nxt = DONE;
`endif
        end
      end
      TRAIL: begin
        if (ser_ready) state_nxt = DONE;
      end
      DONE: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q     <= 1'b0;
      start_armed <= 1'b0;
      rd_addr     <= '0;
      pix_cnt     <= '0;
      pf_valid    <= 1'b0;
      cap_pend    <= 1'b0;
      last_loaded <= 1'b0;
    end else begin
      start_q <= start;
      if (!start) start_armed <= 1'b1;
      if (start_go) begin
        rd_addr     <= '0;
        pix_cnt     <= '0;
        pf_valid    <= 1'b0;
        cap_pend    <= 1'b0;
        last_loaded <= 1'b0;
      end else if (pix_load) begin
        // rd_addr already points at the next pixel; advancing it here lets the
        // RAM return that pixel for capture on the following cycle.
        pf_valid <= 1'b0;
        pix_cnt  <= pix_cnt + ADDR_W'(1);
        if (pix_cnt == LAST_ADDR) last_loaded <= 1'b1;
        else                      cap_pend    <= 1'b1;
        if (rd_addr != LAST_ADDR) rd_addr <= rd_addr + ADDR_W'(1);
      end else if (capture) begin
        pf_valid <= 1'b1;
        cap_pend <= 1'b0;
        if (state == CAPTURE && rd_addr != LAST_ADDR) rd_addr <= rd_addr + ADDR_W'(1);
      end
    end
  end

  // Prefetch stage: RAM data -> byte held for the serializer
  always_ff @(posedge clk) begin
    if (capture) pf_data_p1 <= rd_data;
  end

`ifdef IMG_TX_CHECKSUM_EN
  // Checksum stage: running sum of bytes handed to the serializer
  always_ff @(posedge clk) begin
    if (start_go)      sum_p1 <= '0;
    else if (pix_load) sum_p1 <= sum_p1 + pf_data_p1;
  end
`endif

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .load (ser_load),
    .din  (ser_din),
    .ready(ser_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_image_uart_streamer.sv
// Bench for image_uart_streamer on a 4x4 image at 4 clocks per bit.
module tb_image_uart_streamer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int ADDR_W = 4;
  localparam int CPB = 4;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int FRAME = 10 * CPB;
  localparam int LOGN = 8192;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0] rd_data;
  logic tx, busy, tx_done;

  logic [7:0] mem [0:NPIX-1];
  logic [7:0] exp_q [$];
  logic tx_log [0:LOGN-1];
  logic done_log [0:LOGN-1];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  image_uart_streamer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      tx_log[cyc]   <= tx;
      done_log[cyc] <= tx_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_low(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (tx_log[c] !== 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (done_log[c] === 1'b1) n++;
    return n;
  endfunction

  // Expected byte stream: pixels in address order, plus the mod-256 sum when enabled.
  task automatic build_exp();
    int sum = 0;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back(mem[i]);
      sum = sum + int'(mem[i]);
    end
`ifdef IMG_TX_CHECKSUM_EN
    exp_q.push_back(8'(sum % 256));
`endif
  endtask

  // k: cycle after which start was raised (edge sampled at cycle k+1).
  task automatic check_image(input int k, input string tag);
    int tf, td, nb, nd;
    logic [9:0] obs;
    nb = exp_q.size();
    tf = -1;
    for (int c = k + 1; c <= k + 20; c++) if (tf < 0 && tx_log[c] === 1'b0) tf = c;
    chk($sformatf("%s_first_start", tag), tf, k + 4);
    if (tf < 0) tf = k + 4;
    for (int f = 0; f < nb; f++) begin
      for (int b = 0; b < 10; b++) begin
        obs[b] = tx_log[tf + f * FRAME + b * CPB];
        for (int j = 1; j < CPB; j++)
          if (tx_log[tf + f * FRAME + b * CPB + j] !== obs[b]) obs[b] = 1'bx;
      end
      chk($sformatf("%s_frame%0d", tag, f), {22'd0, obs}, {22'd0, 1'b1, exp_q[f], 1'b0});
    end
    td = -1;
    nd = 0;
    for (int c = tf; c <= tf + nb * FRAME + 30; c++) begin
      if (done_log[c] === 1'b1) begin
        nd++;
        if (td < 0) td = c;
      end
    end
    chk($sformatf("%s_done_cycle", tag), td, tf + nb * FRAME);
    chk($sformatf("%s_done_pulses", tag), nd, 1);
  endtask

  int k, c0;

  initial begin
    rst = 1'b1;
    start = 1'b1;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i * 17);
    repeat (3) tick();
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_addr", {28'd0, rd_addr}, 0);
    chk("rst_done", {31'd0, tx_done}, 0);

    // start already high at reset release is not an edge
    rst = 1'b0;
    c0 = cyc;
    run_to(c0 + 10);
    chk("start_high_at_release_busy", {31'd0, busy}, 0);
    chk("start_high_at_release_tx", count_low(c0, cyc - 1), 0);

    start = 1'b0;
    c0 = cyc;
    run_to(c0 + 50);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_tx", count_low(c0, cyc - 1), 0);

    // image 1: ramp, with a start re-toggle mid-transfer
    build_exp();
    start = 1'b1;
    k = cyc;
    run_to(k + 100);
    chk("busy_mid", {31'd0, busy}, 1);
    start = 1'b0;
    tick();
    start = 1'b1;
    run_to(k + exp_q.size() * FRAME + 40);
    check_image(k, "img1");
    chk("addr_hold", {28'd0, rd_addr}, NPIX - 1);
    chk("busy_after", {31'd0, busy}, 0);
    c0 = cyc;
    run_to(c0 + 100);
    chk("held_start_no_retrigger", count_low(c0, cyc - 1), 0);
    chk("held_start_busy", {31'd0, busy}, 0);

    // image 2: random pixels
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    build_exp();
    start = 1'b0;
    tick();
    start = 1'b1;
    k = cyc;
    run_to(k + exp_q.size() * FRAME + 40);
    check_image(k, "img2");

    // reset during the data bits of byte 5 (0x55, bit 1 = 0)
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i * 17);
    build_exp();
    start = 1'b0;
    tick();
    start = 1'b1;
    k = cyc;
    run_to(k + 4 + 5 * FRAME + CPB + 6);
    chk("pre_rst_tx", {31'd0, tx}, 0);
    chk("pre_rst_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", {31'd0, tx}, 1);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    repeat (2) tick();
    rst = 1'b0;
    c0 = cyc;
    run_to(c0 + 60);
    chk("rst_mid_no_done", count_done(k, cyc - 1), 0);
    chk("rst_mid_idle_tx", count_low(c0, cyc - 1), 0);

    // restart after abort: begins again from address 0
    start = 1'b0;
    tick();
    start = 1'b1;
    k = cyc;
    run_to(k + exp_q.size() * FRAME + 40);
    check_image(k, "img3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
